// File: rtl/writeback_register_file.sv
// Integer register file x0-x31 with writeback source select and a one-entry load-pending stage.
// Optional macro WRITEBACK_BYPASS_EN forwards same-cycle write data to the read ports.
module writeback_register_file #(
  parameter int unsigned RESET_CLEARS_REGS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        writebackValid,
  output logic        writebackReady,
  input  logic [1:0]  writebackSource,
  input  logic [4:0]  rdAddress,
  input  logic [31:0] immediateFormerOutput,
  input  logic [31:0] aluOutput,
  input  logic [31:0] memoryLoadData,
  input  logic [4:0]  rs1Address,
  input  logic [4:0]  rs2Address,
  output logic [31:0] rs1Data,
  output logic [31:0] rs2Data,
  output logic [31:0] writesRetired
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [1:0] SRC_IMM  = 2'b01;
  localparam logic [1:0] SRC_ALU  = 2'b10;
  localparam logic [1:0] SRC_LOAD = 2'b11;

  typedef enum logic {
    IDLE         = 1'b0,
    LOAD_PENDING = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pend_rd_q, pend_rd_d;
  logic [XLEN-1:0] retired_q;
  logic            ready_q;
  logic [XLEN-1:0] regs_q [NREGS];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;

  // Next-state and write-port selection; x0 writes are suppressed here
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    wr_en     = 1'b0;
    wr_addr   = rdAddress;
    wr_data   = aluOutput;
    unique case (state_q)
      IDLE: begin
        if (writebackValid) begin
          unique case (writebackSource)
            SRC_IMM: begin
              wr_en   = (rdAddress != '0);
              wr_data = immediateFormerOutput;
            end
            SRC_ALU: begin
              wr_en   = (rdAddress != '0);
              wr_data = aluOutput;
            end
            SRC_LOAD: begin
              pend_rd_d = rdAddress;
              state_d   = LOAD_PENDING;
            end
            default: ;
          endcase
        end
      end
      LOAD_PENDING: begin
        wr_en   = (pend_rd_q != '0);
        wr_addr = pend_rd_q;
        wr_data = memoryLoadData;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      ready_q   <= (state_d == IDLE);
    end
  end

  // Counter only moves on a committed write, so it holds otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
    end else if (wr_en) begin
      retired_q <= retired_q + XLEN'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if (RESET_CLEARS_REGS != 0) begin
        for (int i = 0; i < int'(NREGS); i++) begin
          regs_q[i] <= '0;
        end
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1Data = (rs1Address == '0) ? '0 : regs_q[rs1Address];
    rs2Data = (rs2Address == '0) ? '0 : regs_q[rs2Address];
`ifdef WRITEBACK_BYPASS_EN
    // wr_en already excludes x0, so a match implies a nonzero address
    if (!reset && wr_en && (wr_addr == rs1Address)) rs1Data = wr_data;
    if (!reset && wr_en && (wr_addr == rs2Address)) rs2Data = wr_data;
`endif
  end

  assign writebackReady = ready_q;
  assign writesRetired  = retired_q;

endmodule

// File: tb/tb_writeback_register_file.sv
// Randomized bench for writeback_register_file against an array/queue-level reference model.
module tb_writeback_register_file;

`ifdef WRITEBACK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        writebackValid;
  logic        writebackReady;
  logic [1:0]  writebackSource;
  logic [4:0]  rdAddress;
  logic [31:0] immediateFormerOutput;
  logic [31:0] aluOutput;
  logic [31:0] memoryLoadData;
  logic [4:0]  rs1Address;
  logic [4:0]  rs2Address;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [31:0] writesRetired;

  writeback_register_file dut (
    .clock                 (clock),
    .reset                 (reset),
    .writebackValid        (writebackValid),
    .writebackReady        (writebackReady),
    .writebackSource       (writebackSource),
    .rdAddress             (rdAddress),
    .immediateFormerOutput (immediateFormerOutput),
    .aluOutput             (aluOutput),
    .memoryLoadData        (memoryLoadData),
    .rs1Address            (rs1Address),
    .rs2Address            (rs2Address),
    .rs1Data               (rs1Data),
    .rs2Data               (rs2Data),
    .writesRetired         (writesRetired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: architectural registers, retire count, one outstanding load
  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  bit          m_pending;
  logic [4:0]  m_prd;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit wen,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (BYPASS && wen && (wa == a)) return wd;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count   = 32'd0;
    m_pending = 1'b0;
    m_prd     = 5'd0;
  endtask

  // One clock: drive at negedge, check before the rising edge, then advance the model
  task automatic cycle(input logic rst, input logic vld, input logic [1:0] src,
                       input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] a1, input logic [4:0] a2);
    bit          wen;
    logic [4:0]  wa;
    logic [31:0] wd;
    @(negedge clock);
    reset                 = rst;
    writebackValid        = vld;
    writebackSource       = src;
    rdAddress             = rd;
    immediateFormerOutput = imm;
    aluOutput             = alu;
    memoryLoadData        = mem;
    rs1Address            = a1;
    rs2Address            = a2;
    #1;
    wen = 1'b0;
    wa  = 5'd0;
    wd  = 32'd0;
    if (!rst) begin
      if (m_pending) begin
        wa = m_prd; wd = mem; wen = (m_prd != 5'd0);
      end else if (vld && (src == 2'b01 || src == 2'b10)) begin
        wa = rd; wd = (src == 2'b01) ? imm : alu; wen = (rd != 5'd0);
      end
    end
    check32("rs1Data", rs1Data, model_read(a1, wen, wa, wd));
    check32("rs2Data", rs2Data, model_read(a2, wen, wa, wd));
    check32("writebackReady", 32'(writebackReady), 32'(!m_pending));
    check32("writesRetired", writesRetired, m_count);
    if (rst) begin
      model_reset();
    end else begin
      if (wen) begin
        m_regs[wa] = wd;
        m_count    = m_count + 32'd1;
      end
      if (m_pending) m_pending = 1'b0;
      else if (vld && src == 2'b11) begin
        m_pending = 1'b1;
        m_prd     = rd;
      end
    end
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
    cycle(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, a1, a2);
  endtask

  initial begin
    reset = 1'b1; writebackValid = 1'b0; writebackSource = 2'b00; rdAddress = 5'd0;
    immediateFormerOutput = 32'd0; aluOutput = 32'd0; memoryLoadData = 32'd0;
    rs1Address = 5'd0; rs2Address = 5'd0;
    repeat (2) @(posedge clock);
    model_reset();

    // Reset state
    cycle(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd31);
    idle_read(5'd1, 5'd31);
    check32("x1_after_reset", rs1Data, 32'd0);
    check32("x31_after_reset", rs2Data, 32'd0);
    check32("ready_after_reset", 32'(writebackReady), 32'd1);
    check32("count_after_reset", writesRetired, 32'd0);

    // Immediate write to x5, then ALU write to x0 dropped
    cycle(1'b0, 1'b1, 2'b01, 5'd5, 32'h1234_5000, 32'd0, 32'd0, 5'd0, 5'd0);
    cycle(1'b0, 1'b1, 2'b10, 5'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd5, 5'd0);
    check32("x5_imm", rs1Data, 32'h1234_5000);
    check32("count_one", writesRetired, 32'd1);
    idle_read(5'd0, 5'd5);
    check32("x0_still_zero", rs1Data, 32'd0);
    check32("count_x0_unchanged", writesRetired, 32'd1);

    // Load to x7; request in the pending cycle is held off and accepted next cycle
    cycle(1'b0, 1'b1, 2'b11, 5'd7, 32'd0, 32'd0, 32'd0, 5'd7, 5'd0);
    cycle(1'b0, 1'b1, 2'b10, 5'd9, 32'd0, 32'h99, 32'hDEAD_BEEF, 5'd7, 5'd9);
    check32("ready_low_pending", 32'(writebackReady), 32'd0);
    cycle(1'b0, 1'b1, 2'b10, 5'd9, 32'd0, 32'h99, 32'd0, 5'd7, 5'd9);
    check32("x7_load", rs1Data, 32'hDEAD_BEEF);
    check32("x9_not_yet", rs2Data, BYPASS ? 32'h99 : 32'd0);
    idle_read(5'd9, 5'd7);
    check32("x9_accepted", rs1Data, 32'h99);
    check32("count_after_load", writesRetired, 32'd3);

    // Load to x0 still occupies the pending cycle
    cycle(1'b0, 1'b1, 2'b11, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'h1111_2222, 5'd0, 5'd0);
    check32("ready_low_x0_load", 32'(writebackReady), 32'd0);
    idle_read(5'd0, 5'd0);
    check32("count_x0_load", writesRetired, 32'd3);

    // Same-cycle read of the register being written
    cycle(1'b0, 1'b1, 2'b10, 5'd3, 32'd0, 32'h42, 32'd0, 5'd0, 5'd3);
    check32("x3_same_cycle", rs2Data, BYPASS ? 32'h42 : 32'd0);
    idle_read(5'd0, 5'd3);
    check32("x3_next_cycle", rs2Data, 32'h42);

    // Reset during the pending cycle discards the load
    cycle(1'b0, 1'b1, 2'b11, 5'd8, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    cycle(1'b1, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'hAAAA_5555, 5'd0, 5'd0);
    idle_read(5'd8, 5'd3);
    check32("x8_discarded", rs1Data, 32'd0);
    check32("ready_after_reset_pending", 32'(writebackReady), 32'd1);
    check32("count_after_reset_pending", writesRetired, 32'd0);

    // Counter wrap via a preloaded counter value
    idle_read(5'd0, 5'd0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_count = 32'hFFFF_FFFF;
    cycle(1'b0, 1'b1, 2'b01, 5'd12, 32'h0000_0C00, 32'd0, 32'd0, 5'd0, 5'd0);
    idle_read(5'd12, 5'd0);
    check32("count_wrapped", writesRetired, 32'd0);

    // Random traffic, addresses biased low so reads often hit recent writes
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic [4:0] rd, a1, a2;
      r  = ($urandom_range(0, 59) == 0);
      rd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a2 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      cycle(r, 1'($urandom_range(0, 3) != 0), 2'($urandom), rd,
            32'($urandom), 32'($urandom), 32'($urandom), a1, a2);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_register_file.md
Name: writeback_register_file

Overview:
- Integer register file (x0–x31) plus writeback controller for the core.
- Sits directly downstream of the immediate former, ALU and memory interface. Selects one result per retiring instruction and commits it to rd.
- Provides two combinational read ports to the operand stage.
- Memory loads return data one cycle late, so load writebacks pass through a one-entry pending stage, with backpressure to upstream.

Parameters:
- RESET_CLEARS_REGS, 1, 1 = all 31 writable registers cleared on reset; 0 = contents untouched by reset.

Ports:
- clock  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- writebackValid  input  1  retiring instruction presents a writeback request this cycle
- writebackReady  output  1  controller accepts a request this cycle
- writebackSource  input  2  00 none, 01 immediate former (LUI/AUIPC), 10 ALU, 11 memory load
- rdAddress  input  5  destination register
- immediateFormerOutput  input  32  immediate former result
- aluOutput  input  32  ALU result
- memoryLoadData  input  32  load data, valid exactly one cycle after the load request is accepted
- rs1Address  input  5  read port 1 address
- rs2Address  input  5  read port 2 address
- rs1Data  output  32  read port 1 data, combinational
- rs2Data  output  32  read port 2 data, combinational
- writesRetired  output  32  count of committed register writes

Behaviour:
- Reset (synchronous, active-high, wins over every other event):
  - state = IDLE, writebackReady = 1, writesRetired = 0.
  - Pending rd cleared.
  - Registers cleared if RESET_CLEARS_REGS = 1.
  - A load pending when reset asserts is discarded; its data is never written.
- A request is accepted when writebackValid & writebackReady.
- States:
  - IDLE: writebackReady = 1.
    - Accepted source 01/10 with rd != 0: register written at this clock edge; the value is visible on the read ports next cycle. writesRetired += 1.
    - Accepted source 11: latch rd, go to LOAD_PENDING, no write this cycle.
    - Source 00 or rd = 0: accepted, no write, counter unchanged.
  - LOAD_PENDING: writebackReady = 0; any writebackValid is ignored and upstream holds.
    - At the edge, memoryLoadData is written to the latched rd if it is nonzero; writesRetired += 1 only in that case.
    - Return to IDLE. Back-to-back loads therefore sustain one load per 2 cycles.
- x0:
  - Reads of address 0 always return 0.
  - Writes to x0 are dropped and not counted, including a load whose rd = 0 (still goes through LOAD_PENDING).
- Reads: rs1Data/rs2Data = array[addr] combinationally. Same-cycle write data is not visible unless the optional feature is enabled.
- writesRetired is a 32-bit counter and wraps 0xFFFFFFFF → 0 with no flag.
- Both read ports may address the same register; both return the identical value.
- Write data width is 32 bits; no sign/zero extension is done here (loads arrive already extended).

Optional Feature:
- Macro: WRITEBACK_BYPASS_EN.
- When defined: a read port whose address equals the register being written in the current cycle (IDLE immediate/ALU write, or LOAD_PENDING load write) with nonzero rd returns the incoming write data combinationally. Address 0 still reads 0.
- When undefined: reads return the stored value; the new value appears the cycle after the write.

Test Plan:
- Reset, then read x1/x31 → 0 (RESET_CLEARS_REGS = 1); writebackReady = 1; writesRetired = 0.
- Source 01, rd = 5, immediateFormerOutput = 0x12345000 → next cycle rs1Address = 5 reads 0x12345000; writesRetired = 1. Source 10, rd = 0, aluOutput = 0xFFFFFFFF → x0 still reads 0; count unchanged.
- Load request, rd = 7, in cycle N → writebackReady = 0 in N+1. memoryLoadData = 0xDEADBEEF in N+1 → x7 reads 0xDEADBEEF from N+2; a writebackValid asserted in N+1 is ignored and accepted in N+2.
- Reset asserted in the LOAD_PENDING cycle with memoryLoadData = 0xAAAA5555 → rd unchanged (cleared); state IDLE; writesRetired = 0.
- WRITEBACK_BYPASS_EN defined: ALU write rd = 3 = 0x00000042 with rs2Address = 3 in the same cycle → rs2Data = 0x00000042 that cycle. Undefined → old x3 value that cycle, 0x42 next cycle.
- Force writesRetired near wrap (0xFFFFFFFF via 2^32 writes, or backdoor) → one more write gives 0x00000000.
